// File: rtl/rx_pkg.sv
// State encodings and small helpers shared by the RX sequence checker.
package rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HEADER = 3'd1,
        TAIL   = 3'd2,
        DONE   = 3'd3
    } state_t;

    localparam int unsigned IDX_W = 16;

    // The aux byte of the next in-order frame; 255 wraps to 0.
    function automatic logic [7:0] seq_next(input logic [7:0] a);
        return a + 8'd1;
    endfunction

endpackage

// File: rtl/detect_errors.sv
// RX sequence checker: captures the aux byte at a fixed offset in each frame and
// counts complete frames and frames whose aux follows the previous one.
//
//  state  | meaning
//  IDLE   | waiting for a rising edge of rx_en
//  HEADER | counting bytes up to the aux offset
//  TAIL   | aux captured, waiting for the frame to end
//  DONE   | one cycle: update counters and sequence tracking
module detect_errors
    import rx_pkg::*;
#(
    parameter int unsigned whereis_aux = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_en,
    input  logic [7:0]  rx_data,
    output logic [31:0] count,
    output logic [31:0] ok,
    output logic        valid,
    output logic [2:0]  state
);

    localparam logic [IDX_W-1:0] AUX_IDX = IDX_W'(whereis_aux);

    state_t           r_state;
    state_t           w_next;
    logic             w_capture;
    logic             w_start;
    logic             w_in_seq;
    logic             r_rx_en_d;
    logic [IDX_W-1:0] r_idx;
    logic             r_sync;
    logic [7:0]       r_aux;
    logic [7:0]       r_last_aux;
    logic [31:0]      r_count;
    logic [31:0]      r_ok;
    logic             r_valid;

    assign w_start  = rx_en & ~r_rx_en_d;
    assign w_in_seq = (r_aux == seq_next(r_last_aux));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    if (AUX_IDX == '0) begin
                        w_capture = 1'b1;
                        w_next    = TAIL;
                    end else begin
                        w_next = HEADER;
                    end
                end
            end
            HEADER: begin
                if (!rx_en) begin
                    w_next = IDLE;
                end else if (r_idx == AUX_IDX) begin
                    w_capture = 1'b1;
                    w_next    = TAIL;
                end
            end
            TAIL: begin
                if (!rx_en) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // rx_en_d resets high so a frame already running at reset release is not a start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_en_d  <= 1'b1;
            r_idx      <= '0;
            r_sync     <= 1'b0;
            r_aux      <= '0;
            r_last_aux <= '0;
            r_count    <= '0;
            r_ok       <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_rx_en_d <= rx_en;
            r_valid   <= (r_state == DONE);

            if (r_state == HEADER && rx_en) begin
                r_idx <= r_idx + 1'b1;
            end else if (r_state == IDLE && w_start) begin
                r_idx <= IDX_W'(1);
            end else begin
                r_idx <= '0;
            end

            if (w_capture) begin
                r_aux <= rx_data;
            end

            if (r_state == DONE) begin
                r_count    <= r_count + 32'd1;
                r_last_aux <= r_aux;
                r_sync     <= 1'b1;
                if (!r_sync || w_in_seq) begin
                    r_ok <= r_ok + 32'd1;
                end
            end
        end
    end

    assign count = r_count;
    assign ok    = r_ok;
    assign valid = r_valid;
    assign state = r_state;

endmodule

// File: tb/tb_detect_errors.sv
// Directed and randomized frames against a frame-level sequence model.
module tb_detect_errors;

    localparam int AUX_POS = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_en;
    logic [7:0]  rx_data;
    logic [31:0] count;
    logic [31:0] ok;
    logic        valid;
    logic [2:0]  state;

    always #4 clk = ~clk;

    detect_errors #(.whereis_aux(AUX_POS)) dut (
        .clk     (clk),
        .rst     (rst),
        .rx_en   (rx_en),
        .rx_data (rx_data),
        .count   (count),
        .ok      (ok),
        .valid   (valid),
        .state   (state)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;

    logic [31:0] exp_count;
    logic [31:0] exp_ok;
    bit          have_base;
    int          last_aux;

    always @(negedge clk) if (valid === 1'b1) n_valid++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_count = 0;
        exp_ok    = 0;
        have_base = 0;
        last_aux  = 0;
    endtask

    task automatic model_frame(input int aux);
        exp_count++;
        if (!have_base || (aux % 256) == ((last_aux + 1) % 256)) exp_ok++;
        have_base = 1;
        last_aux  = aux % 256;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        rx_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // fill < 0 means random filler bytes
    task automatic send_frame(input int len, input int aux, input int fill, input int idle);
        automatic bit full = (len > AUX_POS);
        automatic logic [7:0] b_aux = 8'(aux);
        for (int b = 0; b < len; b++) begin
            @(negedge clk);
            rx_en   = 1'b1;
            rx_data = (b == AUX_POS) ? b_aux : ((fill < 0) ? 8'($urandom) : 8'(fill));
        end
        @(negedge clk);
        rx_en   = 1'b0;
        rx_data = 'x;
        if (full) model_frame(aux);
        @(negedge clk);
        check("valid_before", {31'b0, valid}, 32'd0);
        @(negedge clk);
        check("valid_pulse", {31'b0, valid}, {31'b0, full});
        check("count", count, exp_count);
        check("ok", ok, exp_ok);
        @(negedge clk);
        check("valid_after", {31'b0, valid}, 32'd0);
        repeat (idle) @(negedge clk);
    endtask

    initial begin
        int v0;
        int a;
        rst     = 1'b1;
        rx_en   = 1'b0;
        rx_data = 8'h00;
        model_reset();

        do_reset();
        check("rst_count", count, 32'd0);
        check("rst_ok", ok, 32'd0);
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_state", {29'b0, state}, 32'd0);

        // 300 frames, wrap 255->0 included
        v0 = n_valid;
        for (int i = 0; i < 300; i++) send_frame(12, i % 256, 8'h99, 7);
        check("run300_count", count, 32'd300);
        check("run300_ok", ok, 32'd300);
        check("run300_valid", 32'(n_valid - v0), 32'd300);

        // baseline at aux=5, random lengths and gaps
        do_reset();
        for (int i = 0; i < 50; i++) send_frame($urandom_range(16, 4), 5 + i, -1, $urandom_range(4, 0));
        check("run50_count", count, 32'd50);
        check("run50_ok", ok, 32'd50);

        // dropped frame 3
        do_reset();
        send_frame(8, 0, -1, 2);
        send_frame(8, 1, -1, 2);
        send_frame(8, 2, -1, 2);
        send_frame(8, 4, -1, 2);
        send_frame(8, 5, -1, 2);
        check("gap_count", count, 32'd5);
        check("gap_ok", ok, 32'd4);

        // short frame between 7 and 8
        do_reset();
        v0 = n_valid;
        send_frame(9, 7, -1, 2);
        send_frame(3, 200, -1, 2);
        send_frame(9, 8, -1, 2);
        check("short_count", count, 32'd2);
        check("short_ok", ok, 32'd2);
        check("short_valid", 32'(n_valid - v0), 32'd2);

        // reset while in TAIL with rx_en high
        send_frame(9, 9, -1, 2);
        for (int b = 0; b < 6; b++) begin
            @(negedge clk);
            rx_en   = 1'b1;
            rx_data = (b == AUX_POS) ? 8'd10 : 8'($urandom);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("midrst_count", count, 32'd0);
        check("midrst_ok", ok, 32'd0);
        check("midrst_state", {29'b0, state}, 32'd0);
        v0 = n_valid;
        repeat (3) @(negedge clk);
        rx_en   = 1'b0;
        rx_data = 'x;
        repeat (5) @(negedge clk);
        check("midrst_noupd", count, 32'd0);
        check("midrst_novalid", 32'(n_valid - v0), 32'd0);
        send_frame(8, 99, -1, 2);
        check("midrst_next_count", count, 32'd1);
        check("midrst_next_ok", ok, 32'd1);

        // randomized mix of in-order, out-of-order and short frames
        do_reset();
        a = $urandom_range(255, 0);
        for (int i = 0; i < 150; i++) begin
            a = ($urandom_range(3, 0) == 0) ? $urandom_range(255, 0) : (a + 1) % 256;
            send_frame($urandom_range(14, 1), a, -1, $urandom_range(3, 0));
        end
        check("rand_count", count, exp_count);
        check("rand_ok", ok, exp_ok);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
